// File: rtl/posit_add_scheduler.sv
// Round-robin scheduler sharing one fixed-latency posit adder among NREQ
// requesters; results return in issue order through a credit-guarded FIFO.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   req_valid/req_ready   per-requester request / combinational grant
//   req_a, req_b, req_sub packed operands (lane i at [i*N +: N]), subtract
//   dp_start, dp_a, dp_b  registered issue to the shared datapath
//   dp_result             datapath sum, sampled when the tag pipe exits
//   res_valid/res_ready   result FIFO head handshake
//   res_data, res_tag     head result and owning requester index
//   busy                  work in flight or buffered
module posit_add_scheduler #(
  parameter int N     = 8,
  parameter int ES    = 3,
  parameter int NREQ  = 4,
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int TW    = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic              dp_start,
  output logic [N-1:0]      dp_a,
  output logic [N-1:0]      dp_b,
  input  logic [N-1:0]      dp_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_data,
  output logic [TW-1:0]     res_tag,
  output logic              busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (ES < 0 || ES >= N || NREQ < 2 || LAT < 1 || DEPTH < 1)
  begin : g_param_chk
    $error("posit_add_scheduler: illegal parameters");
  end

  logic [TW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic [NREQ-1:0] cand;
  logic            grant;
  logic [TW-1:0]   win;
  logic            pop;
  logic            wr;

  logic            dp_start_q;
  logic [N-1:0]    dp_a_q, dp_b_q;
  logic [N-1:0]    sel_a, sel_b, neg_b;

  logic [LAT-1:0]          pv_q;
  logic [LAT-1:0][TW-1:0]  pt_q;

  logic [N-1:0]    mem_data_q [DEPTH];
  logic [TW-1:0]   mem_tag_q  [DEPTH];
  logic [PW-1:0]   wp_q, rp_q;
  logic [CW-1:0]   cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Gating with reset_n keeps req_ready low while reset is held.
  assign cand = req_valid
              & {NREQ{(credits_q != '0) && reset_n}};

  // Two passes: upper half from rr_ptr first, then wrap to lane 0.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!grant && cand[j] && TW'(j) >= rr_ptr_q) begin
        grant = 1'b1;
        win   = TW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!grant && cand[j]) begin
        grant = 1'b1;
        win   = TW'(j);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant)
      rr_ptr_d = (win == TW'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  // Two's complement is posit negation; 0 and NaR are fixed points.
  assign sel_a = req_a[win*N +: N];
  assign sel_b = req_b[win*N +: N];
  assign neg_b = (~sel_b) + 1'b1;

  assign pop = res_valid & res_ready;
  assign wr  = pv_q[LAT-1];

  always_comb begin
    credits_d = credits_q;
    unique case ({grant, pop})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      credits_q  <= CW'(DEPTH);
      dp_start_q <= 1'b0;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      credits_q  <= credits_d;
      dp_start_q <= grant;
      if (grant) begin
        dp_a_q <= sel_a;
        dp_b_q <= req_sub[win] ? neg_b : sel_b;
      end
    end
  end

  // Stage 0 loads on the issue edge, alongside dp_start, so the
  // last stage lines up with dp_result and the FIFO write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv_q <= '0;
      pt_q <= '0;
    end else begin
      pv_q[0] <= grant;
      pt_q[0] <= win;
      for (int k = 1; k < LAT; k++) begin
        pv_q[k] <= pv_q[k-1];
        pt_q[k] <= pt_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_data_q[k] <= '0;
        mem_tag_q[k]  <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (wr) begin
        mem_data_q[wp_q] <= dp_result;
        mem_tag_q[wp_q]  <= pt_q[LAT-1];
        wp_q             <= ptr_inc(wp_q);
      end
      if (pop) rp_q <= ptr_inc(rp_q);
    end
  end

  assign dp_start  = dp_start_q;
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign res_valid = (cnt_q != '0);
  assign res_data  = mem_data_q[rp_q];
  assign res_tag   = mem_tag_q[rp_q];
  assign busy      = (|pv_q) | res_valid | dp_start_q;

endmodule

// File: doc/posit_add_scheduler.md
Name: posit_add_scheduler

Overview:
- Shares one fixed-latency posit adder datapath (extract -> alignment/mantissa add -> normalise/encode) among NREQ requesters.
- Performs round-robin arbitration and issues at most one operation per cycle.
- Tracks in-flight operations by tag and returns results in issue order through a credit-protected result FIFO with valid/ready backpressure.

Parameters:
- N, 8, posit word width.
- ES, 3, posit exponent field width. Passed through to the datapath; unused in scheduler logic.
- NREQ, 4, number of requesters (>=2).
- LAT, 3, datapath latency in cycles from dp_start to dp_result valid (>=1).
- DEPTH, 4, result FIFO entries (>=1).
- TW, log2(NREQ), tag width (minimum 1).

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  per-requester grant. Combinational; depends on req_valid.
- req_a  in  NREQ*N  operand A, requester i at [i*N +: N].
- req_b  in  NREQ*N  operand B, same packing as req_a.
- req_sub  in  NREQ  1 = A-B, 0 = A+B.
- dp_start  out  1  issue strobe to the datapath.
- dp_a  out  N  datapath operand A.
- dp_b  out  N  datapath operand B, already negated when the operation is a subtraction.
- dp_result  in  N  datapath sum. Sampled LAT cycles after the matching dp_start.
- res_valid  out  1  result available at the FIFO head.
- res_ready  in  1  consumer accepts the result.
- res_data  out  N  result posit.
- res_tag  out  TW  index of the requester that owns res_data.
- busy  out  1  high when any operation is in flight or the FIFO is non-empty.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - req_ready=0, dp_start=0, dp_a=0, dp_b=0, res_valid=0, res_data=0, res_tag=0, busy=0.
  - rr_ptr=0, credits=DEPTH, pipeline valid/tag shift register cleared, FIFO empty.
  - Asserting reset mid-operation discards all in-flight and buffered results. Any dp_result arriving after release is ignored because its valid bits were cleared.
- Credits:
  - credits = DEPTH - (in-flight + FIFO occupancy).
  - Decrements on each issue, increments on each res handshake (res_valid & res_ready).
  - Issue and handshake in the same cycle leave credits unchanged.
  - Issue is allowed only when credits>0, so the FIFO can never overflow and dp_result is never dropped.
- Arbitration:
  - Candidates are requesters with req_valid=1 and issue_ok (credits>0).
  - Winner = first candidate at or after rr_ptr, searching upward and wrapping modulo NREQ.
  - req_ready[winner]=1; all other bits are 0.
  - After a grant, rr_ptr = winner+1 (mod NREQ). With no grant, rr_ptr holds.
- Issue datapath (registered, one cycle after the grant):
  - dp_start=1, dp_a=req_a[winner].
  - dp_b = req_sub ? (~req_b+1) mod 2^N : req_b. This is posit negation: 0x00 and NaR (1 followed by N-1 zeros) map to themselves.
  - dp_a and dp_b hold their last values when dp_start=0.
- Tracking:
  - A shift register of {valid, tag} with LAT stages is loaded at dp_start.
  - When stage LAT is valid, {dp_result, tag} is written to the FIFO in that same cycle.
  - Total issue-to-res_valid latency = 1 + LAT cycles (grant cycle to first cycle res_valid=1) when the FIFO is empty.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a full/empty count.
  - res_valid = !empty; res_data/res_tag = head entry.
  - Simultaneous write and read when the FIFO is not empty: count unchanged, both pointers advance.
  - Results are strictly in issue order. Results are not reordered per requester.
- busy = (any pipeline valid) | !empty | dp_start.

Test Plan:
- Reset then idle: reset_n low for 2 cycles with all req_valid=1 -> all outputs 0, credits=4. First grant to requester 0 in the first cycle after release.
- Single add: req0 with a=0x40, b=0x40 (1.0+1.0), behavioural datapath model LAT=3 -> dp_start one cycle after grant, dp_a=0x40, dp_b=0x40. res_valid 4 cycles after grant, res_data=0x44, res_tag=0.
- Subtract negation: req2 with a=0x40, b=0x40, sub=1 -> dp_b=0xC0, res_data=0x00, res_tag=2. sub=1 with b=0x80 -> dp_b=0x80.
- Round-robin fairness: all 4 requesters held valid, res_ready=1 -> grant order 0,1,2,3,0,1,... with exactly one req_ready bit per cycle. Result tags follow the same order.
- Backpressure/credits: res_ready=0, all requesters valid -> exactly 4 grants, then req_ready=0. FIFO fills to 4 with no loss. Raising res_ready for 1 cycle -> exactly one new grant. Issue and pop in the same cycle leave credits at 0.
- Reset mid-flight: assert reset_n=0 with 3 operations in flight -> res_valid=0 immediately. After release, no stale result appears even though dp_result keeps toggling. busy=0.
